block_dispatcher: RTL

Parametrised kernel-level block dispatcher for the GPU top level. It accepts a total kernel thread count and splits it into blocks of `THREADS_PER_BLOCK` threads, with a partial tail block where needed. It hands blocks out dynamically to free, enabled compute cores using a round-robin arbiter, one grant per cycle, and re-dispatches to cores as they finish. It replaces static one-block-per-core dispatch and raises `done`, or `err` for an unservable launch.

---
 rtl/block_dispatcher_pkg.sv | 24 ++
 rtl/block_dispatcher_rr_arbiter.sv | 33 +++
 rtl/block_dispatcher.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_dispatcher_pkg.sv
// Shared types and sizing helpers for the kernel block dispatcher.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH,
        DONE
    } disp_state_t;

    typedef enum logic {
        FREE,
        BUSY
    } slot_state_t;

    localparam int TPB_DEFAULT = 4;
    localparam int TC_W        = $clog2(TPB_DEFAULT) + 1;

    // Width needed to hold a per-block thread count in 1..tpb.
    function automatic int tc_width(input int tpb);
        return $clog2(tpb) + 1;
    endfunction

endpackage

// File: rtl/block_dispatcher_rr_arbiter.sv
// Rotating find-first arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel into fixed-size thread blocks and hands them out to free,
// enabled cores one grant per cycle, tracking completions until the kernel ends.
module block_dispatcher
    import dispatch_pkg::*;
#(
    parameter  int NUM_CORES         = 2,
    parameter  int THREADS_PER_BLOCK = 4,
    parameter  int THREAD_COUNT_W    = 16,
    parameter  int BLOCK_ID_W        = 8,
    localparam int TCW               = tc_width(THREADS_PER_BLOCK)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [THREAD_COUNT_W-1:0]       thread_count,
    input  logic [NUM_CORES-1:0]            core_enable,
    input  logic [NUM_CORES-1:0]            core_done,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [NUM_CORES-1:0]            core_reset,
    output logic [NUM_CORES*BLOCK_ID_W-1:0] core_block_id,
    output logic [NUM_CORES*TCW-1:0]        core_thread_count,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int W       = THREAD_COUNT_W;
    localparam int TPB_LOG = $clog2(THREADS_PER_BLOCK);
    localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    disp_state_t       state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [W-1:0]      total_q, total_d;
    logic [W-1:0]      disp_q, disp_d;
    logic [W-1:0]      comp_q, comp_d;
    logic [TCW-1:0]    last_tc_q, last_tc_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    slot_state_t       slot_q [NUM_CORES];
    slot_state_t       slot_d [NUM_CORES];
    logic [BLOCK_ID_W-1:0] bid_q [NUM_CORES];
    logic [BLOCK_ID_W-1:0] bid_d [NUM_CORES];
    logic [TCW-1:0]    btc_q [NUM_CORES];
    logic [TCW-1:0]    btc_d [NUM_CORES];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              err_pend_q, err_pend_d;

    // Launch arithmetic: ceil division by a power of two, and the tail size.
    logic [W:0]     n_round;
    logic [W-1:0]   launch_blocks;
    logic [W-1:0]   launch_floor;
    logic [W-1:0]   launch_rem;
    logic [TCW-1:0] launch_last_tc;

    assign n_round        = {1'b0, thread_count} + (W + 1)'(THREADS_PER_BLOCK - 1);
    assign launch_blocks  = W'(n_round >> TPB_LOG);
    assign launch_floor   = thread_count >> TPB_LOG;
    assign launch_rem     = thread_count - (launch_floor << TPB_LOG);
    assign launch_last_tc = (launch_rem == '0) ? TCW'(THREADS_PER_BLOCK) : TCW'(launch_rem);

    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] done_hit;
    logic [W-1:0]         n_done;
    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;

    // Slots freed this edge are still BUSY in slot_q, so they cannot be re-granted yet.
    always_comb begin
        req      = '0;
        done_hit = '0;
        n_done   = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            req[c]      = mask_q[c] && (slot_q[c] == FREE);
            done_hit[c] = (slot_q[c] == BUSY) && core_done[c];
            if (done_hit[c]) begin
                n_done = n_done + W'(1);
            end
        end
    end

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .req        (req),
        .ptr        (rr_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        total_d    = total_q;
        disp_d     = disp_q;
        comp_d     = comp_q;
        last_tc_d  = last_tc_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_pend_d = err_pend_q;
        for (int c = 0; c < NUM_CORES; c++) begin
            slot_d[c] = slot_q[c];
            bid_d[c]  = bid_q[c];
            btc_d[c]  = btc_q[c];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    mask_d    = core_enable;
                    total_d   = launch_blocks;
                    last_tc_d = launch_last_tc;
                    disp_d    = '0;
                    comp_d    = '0;
                    if (thread_count == '0) begin
                        state_d    = FINISH;
                        err_pend_d = 1'b0;
                    end else if (core_enable == '0) begin
                        state_d    = FINISH;
                        err_pend_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        err_pend_d = 1'b0;
                    end
                end
            end

            RUN: begin
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (done_hit[c]) begin
                        slot_d[c] = FREE;
                    end
                end
                comp_d = comp_q + n_done;

                if ((disp_q < total_q) && grant_valid) begin
                    for (int c = 0; c < NUM_CORES; c++) begin
                        if (grant_idx == PTR_W'(c)) begin
                            slot_d[c] = BUSY;
                            bid_d[c]  = BLOCK_ID_W'(disp_q);
                            btc_d[c]  = (disp_q == total_q - W'(1)) ? last_tc_q
                                                                    : TCW'(THREADS_PER_BLOCK);
                        end
                    end
                    disp_d = disp_q + W'(1);
                    rr_d   = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
                end

                if (comp_d == total_q) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = err_pend_q;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            total_q    <= '0;
            disp_q     <= '0;
            comp_q     <= '0;
            last_tc_q  <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            for (int c = 0; c < NUM_CORES; c++) begin
                slot_q[c] <= FREE;
                bid_q[c]  <= '0;
                btc_q[c]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            total_q    <= total_d;
            disp_q     <= disp_d;
            comp_q     <= comp_d;
            last_tc_q  <= last_tc_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            for (int c = 0; c < NUM_CORES; c++) begin
                slot_q[c] <= slot_d[c];
                bid_q[c]  <= bid_d[c];
                btc_q[c]  <= btc_d[c];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core_out
            assign core_start[gi] = (slot_q[gi] == BUSY);
            assign core_reset[gi] = (slot_q[gi] == FREE);
            assign core_block_id[gi*BLOCK_ID_W +: BLOCK_ID_W] = bid_q[gi];
            assign core_thread_count[gi*TCW +: TCW]           = btc_q[gi];
        end
    endgenerate

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
